boot_loader: RTL and testbench
==============================

// Module: boot_loader
// PURPOSE
//   Loads the program image into instruction memory ahead of the processor, then releases processor reset.
//   Sits upstream of the single-cycle core and its instruction memory.
//   Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
//   Writes each word to consecutive word addresses through the memory write port.
//   Holds cpu_reset high until the full image is written.
// PARAMETERS
//   ADDR_WIDTH  8  word-address width of instruction memory (capacity 2**ADDR_WIDTH words)
// PORTS
//   clock       in   1           single system clock, all state on rising edge
//   reset       in   1           synchronous, active-high
//   byte_valid  in   1           byte_data is valid this cycle
//   byte_data   in   8           stream byte
//   byte_ready  out  1           loader accepts byte_data this cycle
//   start       in   1           1-cycle pulse: reload a new image (honoured only in DONE or ERROR)
//   mem_we      out  1           instruction-memory write strobe, 1 cycle per word
//   mem_addr    out  ADDR_WIDTH  word address of the write
//   mem_wdata   out  32          word written
//   cpu_reset   out  1           drives processor reset; 1 while loading
//   done        out  1           image loaded, processor running
//   error       out  1           declared word count exceeds capacity
// BEHAVIOUR
//   Reset: state=CNT_LO, cpu_reset=1, done=0, error=0, mem_we=0, mem_addr=0, mem_wdata=0, byte_ready=1.
//   A byte is accepted when byte_valid & byte_ready are both 1 at the rising edge. No bytes are lost or duplicated.
//   Stream format: count[7:0], count[15:8], then count*4 data bytes. The first byte of each word goes to bits [7:0].
//   States:
//     CNT_LO  ready=1; on accept: latch count low byte -> CNT_HI.
//     CNT_HI  ready=1; on accept: latch count high byte.
//             count==0 -> DONE.
//             count > 2**ADDR_WIDTH -> ERROR.
//             otherwise -> DATA, with word index=0 and byte index=0.
//     DATA    ready=1; on accept: shift byte into the assembly register.
//             On the 4th byte -> WRITE.
//     WRITE   ready=0, 1 cycle. mem_we=1, mem_addr=word index, mem_wdata=assembled word.
//             Then word index+1.
//             Last word -> DONE; otherwise -> DATA.
//     DONE    ready=0, cpu_reset=0, done=1; start -> CNT_LO.
//     ERROR   ready=0, cpu_reset=1, error=1; start -> CNT_LO.
//   All outputs are registered. mem_we is high exactly in the cycle after the 4th byte of a word is accepted.
//   cpu_reset falls in the same cycle done rises, i.e. the cycle after the last WRITE.
//   start pulse: cpu_reset=1 and done=error=0 from the next cycle.
//     Memory contents are not cleared; mem_addr restarts at 0.
//   start outside DONE/ERROR is ignored. byte_valid in DONE/ERROR is ignored; those bytes are not accepted.
//   count == 2**ADDR_WIDTH is legal: the final write goes to the top address, and the word index does not wrap before DONE.
//   reset mid-load: the partial word is discarded, the state returns to CNT_LO, and written words stay in memory.
//   mem_addr/mem_wdata hold their last values when mem_we=0.
// TESTING
//   1. Stream 02 00 13 05 a0 00 93 05 10 00
//      -> mem_we at addr0=0x00a00513 and addr1=0x00100593;
//      -> cpu_reset=0, done=1 one cycle after the 2nd write.
//   2. Stream 00 00 -> no mem_we; done=1 and cpu_reset=0 the cycle after the 2nd byte.
//   3. ADDR_WIDTH=8, count 01 01 (257) -> error=1, cpu_reset=1, byte_ready=0; further bytes are not accepted.
//   4. byte_valid toggled randomly (gaps of 0-3 cycles) over a 4-word image
//      -> identical writes to the gap-free run, and byte_ready=0 during each WRITE cycle.
//   5. After done, pulse start, then stream 01 00 ef be ad de
//      -> cpu_reset=1 during the load, one write addr0=0xdeadbeef, then done=1.
//   6. reset asserted after 6 data bytes of a 3-word image
//      -> addr0 written once, no write of the partial word;
//      -> after reset, a fresh stream loads correctly from addr0.

Source files
------------

// File: rtl/boot_loader.sv
// boot_loader: receives a length-prefixed little-endian byte stream, writes
// the assembled 32-bit words to instruction memory, then releases cpu_reset.
module boot_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    input  logic                  start,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_CNT_LO,
        S_CNT_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    // Capacity in words; a 33-bit compare keeps count == capacity legal.
    localparam logic [32:0] CAPACITY = 33'd1 << ADDR_WIDTH;

    state_t                state, state_nx;
    logic [7:0]            cnt_lo_q;
    logic [15:0]           count_q;
    logic [ADDR_WIDTH:0]   widx_q;     // one extra bit so a full image never wraps
    logic [1:0]            bidx_q;
    logic [23:0]           asm_q;      // first three bytes of the word in flight

    logic        accept;
    logic [15:0] count_in;
    logic        count_too_big;
    logic        last_word;

    assign accept        = byte_valid & byte_ready;
    assign count_in      = {byte_data, cnt_lo_q};
    assign count_too_big = 33'(count_in) > CAPACITY;
    assign last_word     = (33'(widx_q) + 33'd1) == 33'(count_q);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= S_CNT_LO;
        else       state <= state_nx;
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_CNT_LO: if (accept) state_nx = S_CNT_HI;
            S_CNT_HI: begin
                if (accept) begin
                    if (count_in == 16'd0)  state_nx = S_DONE;
                    else if (count_too_big) state_nx = S_ERROR;
                    else                    state_nx = S_DATA;
                end
            end
            S_DATA:   if (accept && bidx_q == 2'd3) state_nx = S_WRITE;
            S_WRITE:  state_nx = last_word ? S_DONE : S_DATA;
            S_DONE:   if (start) state_nx = S_CNT_LO;
            S_ERROR:  if (start) state_nx = S_CNT_LO;
            default:  state_nx = S_CNT_LO;
        endcase
    end

    // Datapath plus registered outputs, decoded from the next state so every
    // output changes on the same edge as the state it belongs to.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_lo_q   <= '0;
            count_q    <= '0;
            widx_q     <= '0;
            bidx_q     <= '0;
            asm_q      <= '0;
            byte_ready <= 1'b1;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            byte_ready <= state_nx inside {S_CNT_LO, S_CNT_HI, S_DATA};
            cpu_reset  <= state_nx != S_DONE;
            done       <= state_nx == S_DONE;
            error      <= state_nx == S_ERROR;
            mem_we     <= state_nx == S_WRITE;

            if (accept) begin
                unique case (state)
                    S_CNT_LO: cnt_lo_q <= byte_data;
                    S_CNT_HI: begin
                        count_q <= count_in;
                        widx_q  <= '0;
                        bidx_q  <= '0;
                    end
                    S_DATA: begin
                        asm_q  <= {byte_data, asm_q[23:8]};
                        bidx_q <= bidx_q + 2'd1;
                    end
                    default: ;
                endcase
            end

            // Fourth byte completes the word; present it for the write cycle.
            if (state == S_DATA && state_nx == S_WRITE) begin
                mem_addr  <= widx_q[ADDR_WIDTH-1:0];
                mem_wdata <= {byte_data, asm_q};
            end

            if (state == S_WRITE) widx_q <= widx_q + 1'b1;

            // A reload restarts addressing; memory itself is left untouched.
            if ((state == S_DONE || state == S_ERROR) && start) mem_addr <= '0;
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: header table, directed sequences and random images
// checked against a stream-level model of the expected memory writes.
module tb_boot_loader;

    localparam int AW  = 8;
    localparam int CAP = 1 << AW;

    logic          clock = 1'b0;
    logic          reset;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          start;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_reset;
    logic          done;
    logic          error;

    boot_loader #(.ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .start      (start),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic       e_done;
        logic       e_err;
        logic       e_ready;
        logic       e_cpu;
    } hdr_vec_t;

    int         checks = 0;
    int         errors = 0;
    wr_t        log_q[$];
    wr_t        exp_q[$];
    wr_t        save_q[$];
    logic [7:0] stream_q[$];
    logic       exp_done;
    logic       exp_error;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Write monitor: logs every write, and a write cycle never accepts bytes
    // and always keeps the processor in reset.
    always @(negedge clock) begin
        if (mem_we === 1'b1) begin
            log_q.push_back('{addr: mem_addr, data: mem_wdata});
            chk("ready_in_write", byte_ready, 0);
            chk("cpu_reset_in_write", cpu_reset, 1);
        end
    end

    // Reference: count from the first two bytes, word i from bytes 2+4i..5+4i.
    task automatic build_expected();
        int  cnt;
        wr_t w;
        cnt = int'(stream_q[0]) + 256 * int'(stream_q[1]);
        exp_q.delete();
        exp_error = cnt > CAP;
        exp_done  = !exp_error;
        if (!exp_error) begin
            for (int i = 0; i < cnt; i++) begin
                w.addr = AW'(i);
                w.data = {stream_q[5+4*i], stream_q[4+4*i], stream_q[3+4*i], stream_q[2+4*i]};
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic make_image(input int n);
        stream_q.delete();
        stream_q.push_back(8'(n));
        stream_q.push_back(8'(n >> 8));
        if (n <= CAP)
            for (int i = 0; i < 4 * n; i++) stream_q.push_back(8'($urandom));
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && t < 20) begin
            @(negedge clock);
            t++;
        end
        chk("accept_timeout", (t < 20), 1);
        @(negedge clock);
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_cpu_reset"}, cpu_reset, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_ready"}, byte_ready, 1);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset      = 1'b1;
        byte_valid = 1'b0;
        start      = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Streams stream_q with random idle gaps, then compares against the model.
    task automatic run_stream(input string tag, input int gap_max);
        int t = 0;
        build_expected();
        log_q.delete();
        foreach (stream_q[i]) begin
            repeat ($urandom_range(gap_max, 0)) @(negedge clock);
            send_byte(stream_q[i]);
        end
        while (!(done || error) && t < 10) begin
            @(negedge clock);
            t++;
        end
        chk({tag, "_nwrites"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            chk({tag, "_addr"}, log_q[i].addr, exp_q[i].addr);
            chk({tag, "_data"}, log_q[i].data, exp_q[i].data);
        end
        chk({tag, "_done"}, done, exp_done);
        chk({tag, "_error"}, error, exp_error);
        chk({tag, "_cpu_reset"}, cpu_reset, !exp_done);
    endtask

    hdr_vec_t tbl[5];

    initial begin
        tbl[0] = '{lo: 8'h00, hi: 8'h00, e_done: 1, e_err: 0, e_ready: 0, e_cpu: 0};
        tbl[1] = '{lo: 8'h01, hi: 8'h01, e_done: 0, e_err: 1, e_ready: 0, e_cpu: 1};
        tbl[2] = '{lo: 8'hff, hi: 8'hff, e_done: 0, e_err: 1, e_ready: 0, e_cpu: 1};
        tbl[3] = '{lo: 8'h00, hi: 8'h01, e_done: 0, e_err: 0, e_ready: 1, e_cpu: 1};
        tbl[4] = '{lo: 8'h05, hi: 8'h00, e_done: 0, e_err: 0, e_ready: 1, e_cpu: 1};

        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        start      = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_reset_state("rst");

        // Header-only vectors: state immediately after the count is taken.
        foreach (tbl[i]) begin
            do_reset();
            log_q.delete();
            send_byte(tbl[i].lo);
            send_byte(tbl[i].hi);
            chk("hdr_done", done, tbl[i].e_done);
            chk("hdr_error", error, tbl[i].e_err);
            chk("hdr_ready", byte_ready, tbl[i].e_ready);
            chk("hdr_cpu_reset", cpu_reset, tbl[i].e_cpu);
            chk("hdr_mem_we", mem_we, 0);
            if (tbl[i].e_err) begin
                byte_valid = 1'b1;
                byte_data  = 8'h5a;
                repeat (3) begin
                    @(negedge clock);
                    chk("err_ready", byte_ready, 0);
                    chk("err_hold", error, 1);
                end
                byte_valid = 1'b0;
                chk("err_nwrites", log_q.size(), 0);
            end
        end

        // Two-word image: write timing and the done/cpu_reset edge.
        do_reset();
        stream_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'ha0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        build_expected();
        log_q.delete();
        foreach (stream_q[i]) send_byte(stream_q[i]);
        chk("t1_we_last", mem_we, 1);
        chk("t1_addr_last", mem_addr, 1);
        chk("t1_done_early", done, 0);
        @(negedge clock);
        chk("t1_done", done, 1);
        chk("t1_cpu_reset", cpu_reset, 0);
        chk("t1_we_after", mem_we, 0);
        chk("t1_addr_hold", mem_addr, 1);
        chk("t1_nwrites", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("t1_w0", log_q[0].data, 32'h00a00513);
            chk("t1_w1", log_q[1].data, 32'h00100593);
            chk("t1_a1", log_q[1].addr, 1);
        end

        // Bytes offered in DONE are not consumed.
        byte_valid = 1'b1;
        byte_data  = 8'h77;
        repeat (3) begin
            @(negedge clock);
            chk("done_ready", byte_ready, 0);
            chk("done_hold", done, 1);
        end
        byte_valid = 1'b0;

        // Reload after done.
        pulse_start();
        chk("t5_cpu_reset", cpu_reset, 1);
        chk("t5_done", done, 0);
        chk("t5_ready", byte_ready, 1);
        chk("t5_addr", mem_addr, 0);
        stream_q = '{8'h01, 8'h00, 8'hef, 8'hbe, 8'had, 8'hde};
        run_stream("t5", 0);
        if (log_q.size() == 1) chk("t5_word", log_q[0].data, 32'hdeadbeef);

        // Same 4-word image, gap-free and with random gaps.
        pulse_start();
        make_image(4);
        run_stream("t4a", 0);
        save_q = log_q;
        pulse_start();
        run_stream("t4b", 3);
        chk("t4_same_n", log_q.size(), save_q.size());
        for (int i = 0; i < save_q.size() && i < log_q.size(); i++)
            chk("t4_same", {log_q[i] == save_q[i]}, 1);

        // Reset after 6 data bytes of a 3-word image.
        do_reset();
        make_image(3);
        build_expected();
        log_q.delete();
        for (int i = 0; i < 8; i++) send_byte(stream_q[i]);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_reset_state("t6");
        repeat (3) @(negedge clock);
        chk("t6_nwrites", log_q.size(), 1);
        if (log_q.size() >= 1) begin
            chk("t6_addr", log_q[0].addr, 0);
            chk("t6_data", log_q[0].data, exp_q[0].data);
        end
        make_image(3);
        run_stream("t6b", 1);

        // Random images, including count 0.
        for (int k = 0; k < 8; k++) begin
            pulse_start();
            make_image((k == 0) ? 0 : int'($urandom_range(12, 1)));
            run_stream("rnd", int'($urandom_range(3, 0)));
        end

        // Full capacity: last write lands at the top address.
        pulse_start();
        make_image(CAP);
        run_stream("full", 0);
        if (log_q.size() == CAP) chk("full_top", log_q[CAP-1].addr, CAP - 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
